// File: rtl/uv_uart_rx_os_pkg.sv
// Shared types and helpers for the oversampled UART receive path.
package uv_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    localparam logic [1:0] PAR_EVEN  = 2'd0;
    localparam logic [1:0] PAR_ODD   = 2'd1;
    localparam logic [1:0] PAR_MARK  = 2'd2;
    localparam logic [1:0] PAR_SPACE = 2'd3;

    function automatic logic [3:0] nbits_to_cnt(input logic [1:0] nbits);
        return 4'd5 + {2'b00, nbits};
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uv_uart_rx_os_if.sv
// Received-byte handshake plus status pulses between the RX engine and the RX queue.
interface uv_uart_rx_os_if;
    logic       rx_vld;
    logic       rx_rdy;
    logic [7:0] rx_dat;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_ovr;
    logic       rx_tmo_pls;
    logic       rx_brk;

    modport master (
        output rx_vld, rx_dat, rx_perr, rx_ferr, rx_ovr, rx_tmo_pls, rx_brk,
        input  rx_rdy
    );

    modport slave (
        input  rx_vld, rx_dat, rx_perr, rx_ferr, rx_ovr, rx_tmo_pls, rx_brk,
        output rx_rdy
    );
endinterface

// File: rtl/uv_uart_rx_os_tick.sv
// Oversample prescaler and per-bit sample counter; phase flags are qualified by tick in the user.
module uv_uart_os_tick #(
    parameter int OSR = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [15:0] clk_div,
    output logic        tick,
    output logic        mid_lo,
    output logic        mid,
    output logic        mid_hi,
    output logic        bit_last
);
    localparam int CW = $clog2(OSR);

    logic [15:0]   div_cnt;
    logic [CW-1:0] smp_cnt;

    // >= lets the prescaler recover at once if clk_div is lowered mid-count
    assign tick     = (div_cnt >= clk_div);
    assign mid_lo   = (smp_cnt == CW'(OSR/2 - 1));
    assign mid      = (smp_cnt == CW'(OSR/2));
    assign mid_hi   = (smp_cnt == CW'(OSR/2 + 1));
    assign bit_last = (smp_cnt == CW'(OSR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            smp_cnt <= bit_last ? '0 : smp_cnt + CW'(1);
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end
endmodule

// File: rtl/uv_uart_rx_os.sv
// Oversampling UART receiver with majority vote, error flags and idle timeout.
// Break handling is built in when UV_UART_RX_BREAK_EN is defined.
//   state    | meaning
//   IDLE     | line idle, waiting for a falling edge
//   START    | validating start bit at mid-bit
//   DATA     | shifting nbits+5 data bits
//   PARITY   | checking the parity bit
//   STOP     | mid-stop decision, load output register
//   BRK_WAIT | break seen, waiting for one bit time of idle
module uv_uart_rx_os
    import uv_uart_pkg::*;
#(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_rx,
    input  logic             rx_en,
    input  logic [1:0]       nbits,
    input  logic             endian,
    input  logic [15:0]      clk_div,
    input  logic             parity_en,
    input  logic [1:0]       parity_type,
    input  logic [TMO_W-1:0] rx_tmo,
    uv_uart_rx_os_if.master  rx_if
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic rxs, rxs_d, fall;
    rx_state_e state, state_n;
    logic tick, mid_lo, mid, mid_hi, bit_last;
    logic smp_a, smp_b, smp_c, bit_end, tick_clr;
    logic v_a, v_b, maj, exp_par;
    logic [7:0] shreg, dat_q;
    logic [2:0] bit_cnt, last_idx, wr_idx;
    logic perr_q, ld_start, shift, par_chk, frame_done, brk_hit;
    logic vld_q, perr_o, ferr_o, ovr_q, tmo_pls_q, tmo_arm;
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            rxs_d  <= rxs;
        end
    end

    assign rxs  = sync_q[SYNC_STAGES-1];
    assign fall = rxs_d & ~rxs;

    // in BRK_WAIT the bit timer restarts on every low sample, so bit_end means a full idle bit
    assign tick_clr = ((state == IDLE) && fall) || ((state == BRK_WAIT) && !rxs);

    uv_uart_os_tick #(.OSR(OSR)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr),
        .clk_div  (clk_div),
        .tick     (tick),
        .mid_lo   (mid_lo),
        .mid      (mid),
        .mid_hi   (mid_hi),
        .bit_last (bit_last)
    );

    assign smp_a   = tick & mid_lo;
    assign smp_b   = tick & mid;
    assign smp_c   = tick & mid_hi;
    assign bit_end = tick & bit_last;
    assign maj     = maj3(v_a, v_b, rxs);

    assign last_idx = 3'(nbits_to_cnt(nbits) - 4'd1);
    assign wr_idx   = endian ? (last_idx - bit_cnt) : bit_cnt;
    assign ld_start = (state == IDLE) && fall && rx_en;

    always_comb begin
        exp_par = 1'b0;
        case (parity_type)
            PAR_EVEN:  exp_par = ^shreg;
            PAR_ODD:   exp_par = ~(^shreg);
            PAR_MARK:  exp_par = 1'b1;
            PAR_SPACE: exp_par = 1'b0;
            default:   exp_par = 1'b0;
        endcase
    end

`ifdef UV_UART_RX_BREAK_EN
    logic all_zero;
    logic brk_q;

    assign brk_hit = (state == STOP) && smp_c && all_zero && !maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_zero <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            brk_q <= brk_hit && rx_en;
            if (ld_start)
                all_zero <= 1'b1;
            else if (shift || par_chk)
                all_zero <= all_zero & ~maj;
        end
    end

    assign rx_if.rx_brk = brk_q;
`else
    assign brk_hit      = 1'b0;
    assign rx_if.rx_brk = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        shift      = 1'b0;
        par_chk    = 1'b0;
        frame_done = 1'b0;
        if (!rx_en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:     if (fall) state_n = START;
                START:    if (smp_c) state_n = maj ? IDLE : DATA;
                DATA: if (smp_c) begin
                    shift = 1'b1;
                    if (bit_cnt >= last_idx) state_n = parity_en ? PARITY : STOP;
                end
                PARITY: if (smp_c) begin
                    par_chk = 1'b1;
                    state_n = STOP;
                end
                STOP: if (smp_c) begin
                    if (brk_hit) begin
                        state_n = BRK_WAIT;
                    end else begin
                        frame_done = 1'b1;
                        state_n    = IDLE;
                    end
                end
                BRK_WAIT: if (bit_end) state_n = IDLE;
                default:  state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_a     <= 1'b1;
            v_b     <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            perr_q  <= 1'b0;
        end else begin
            if (smp_a) v_a <= rxs;
            if (smp_b) v_b <= rxs;
            if (ld_start) begin
                shreg   <= '0;
                bit_cnt <= '0;
                perr_q  <= 1'b0;
            end
            if (shift) begin
                shreg[wr_idx] <= maj;
                bit_cnt       <= bit_cnt + 3'd1;
            end
            if (par_chk) perr_q <= (maj != exp_par);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            perr_o <= 1'b0;
            ferr_o <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (frame_done) begin
                if (vld_q && !rx_if.rx_rdy) begin
                    ovr_q <= 1'b1;
                end else begin
                    vld_q  <= 1'b1;
                    dat_q  <= shreg;
                    perr_o <= perr_q;
                    ferr_o <= ~maj;
                end
            end else if (vld_q && rx_if.rx_rdy) begin
                vld_q <= 1'b0;
            end
        end
    end

    // idle timeout: down-counter reloaded on accept, steps once per bit time at the mid-bit phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            tmo_arm   <= 1'b0;
            tmo_pls_q <= 1'b0;
        end else begin
            tmo_pls_q <= 1'b0;
            if (vld_q && rx_if.rx_rdy) begin
                tmo_cnt <= rx_tmo;
                tmo_arm <= (rx_tmo != '0);
            end else if ((state == IDLE) && fall) begin
                tmo_cnt <= rx_tmo;
            end else if ((state == IDLE) && tmo_arm && smp_c) begin
                if (tmo_cnt <= TMO_W'(1)) begin
                    tmo_pls_q <= 1'b1;
                    tmo_arm   <= 1'b0;
                end else begin
                    tmo_cnt <= tmo_cnt - TMO_W'(1);
                end
            end
        end
    end

    assign rx_if.rx_vld     = vld_q;
    assign rx_if.rx_dat     = dat_q;
    assign rx_if.rx_perr    = perr_o;
    assign rx_if.rx_ferr    = ferr_o;
    assign rx_if.rx_ovr     = ovr_q;
    assign rx_if.rx_tmo_pls = tmo_pls_q;
endmodule
